// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration loader.
// Imported by the word assembler and the loader top.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        DONE
    } state_t;

    function automatic int words_f(input int mem_size, input int cfg_width);
        return mem_size / cfg_width;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfg_word_assembler.sv
// Shifts stream words into a truth-table image, first word in the LSBs.
// Flags the transfer that completes a full table.
module cfg_word_assembler
    import lut_cfg_pkg::*;
#(
    parameter int MEM_SIZE     = 16,
    parameter int CONFIG_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic                    i_shift,
    input  logic [CONFIG_WIDTH-1:0] i_data,
    output logic [MEM_SIZE-1:0]     o_asm_nxt,
    output logic                    o_full
);

    localparam int WORDS = words_f(MEM_SIZE, CONFIG_WIDTH);
    localparam int WCW   = cnt_w(WORDS);
    localparam logic [WCW-1:0] LAST = WCW'(WORDS - 1);

    logic [WCW-1:0] r_cnt;

    assign o_full = i_shift && (r_cnt == LAST);

    // Only the words still waiting for completion are stored.
    generate
        if (WORDS == 1) begin : g_single
            assign o_asm_nxt = i_data;
        end else begin : g_shift
            logic [MEM_SIZE-CONFIG_WIDTH-1:0] r_tail;

            assign o_asm_nxt = {i_data, r_tail};

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_tail <= '0;
                end else if (i_clr) begin
                    r_tail <= '0;
                end else if (i_shift) begin
                    r_tail <= o_asm_nxt[MEM_SIZE-1:CONFIG_WIDTH];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_shift) begin
            r_cnt <= o_full ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lut_config_loader.sv
// Loads a bank of LUT truth tables from a word stream, committing each
// table with a one-hot config_en strobe on a shared config_data bus.
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2 ** INPUTS,
    parameter int CONFIG_WIDTH = 8,
    parameter int NUM_LUTS     = 4
) (
    input  logic                    config_clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CONFIG_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [MEM_SIZE-1:0]     config_data,
    output logic [NUM_LUTS-1:0]     config_en,
    output logic                    busy,
    output logic                    done
);

    generate
        if (MEM_SIZE % CONFIG_WIDTH != 0) begin : g_bad_width
            $error("MEM_SIZE must be a multiple of CONFIG_WIDTH");
        end
    endgenerate

    localparam int LCW = cnt_w(NUM_LUTS);
    localparam logic [LCW-1:0] LAST_LUT = LCW'(NUM_LUTS - 1);

    state_t                r_state;
    logic [LCW-1:0]        r_lut;
    logic [MEM_SIZE-1:0]   r_data;
    logic [NUM_LUTS-1:0]   r_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_xfer;
    logic                  w_full;
    logic [MEM_SIZE-1:0]   w_asm_nxt;

    assign in_ready    = (r_state == LOAD);
    assign w_xfer      = in_valid && in_ready;
    assign config_data = r_data;
    assign config_en   = r_en;
    assign busy        = r_busy;
    assign done        = r_done;

    cfg_word_assembler #(
        .MEM_SIZE     (MEM_SIZE),
        .CONFIG_WIDTH (CONFIG_WIDTH)
    ) u_asm (
        .i_clk     (config_clk),
        .i_rst     (rst),
        .i_clr     (abort),
        .i_shift   (w_xfer),
        .i_data    (in_data),
        .o_asm_nxt (w_asm_nxt),
        .o_full    (w_full)
    );

    // Commit outputs are loaded on the completing transfer so they are
    // already valid throughout the COMMIT cycle.
    always_ff @(posedge config_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_lut   <= '0;
            r_data  <= '0;
            r_en    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_en   <= '0;
            r_done <= 1'b0;
            if (abort) begin
                r_state <= IDLE;
                r_lut   <= '0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state <= LOAD;
                            r_lut   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (w_full) begin
                            r_state <= COMMIT;
                            r_data  <= w_asm_nxt;
                            r_en    <= NUM_LUTS'(1) << r_lut;
                        end
                    end
                    COMMIT: begin
                        if (r_lut == LAST_LUT) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_lut   <= r_lut + 1'b1;
                            r_state <= LOAD;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: a 2-LUT/8-bit instance and a
// 3-LUT/16-bit (one word per table) instance on a shared clock.
module tb_lut_config_loader;

    typedef struct {
        logic [2:0]  en;
        logic [15:0] data;
        int          cyc;
        int          lat;
    } com_t;

    typedef struct {
        logic [7:0]  w0, w1, w2, w3;
        int          gmax;
        logic [15:0] e0, e1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_start = 0, a_abort = 0, a_valid = 0;
    logic [7:0]  a_data = '0;
    logic        a_ready, a_busy, a_done;
    logic [15:0] a_cfg;
    logic [1:0]  a_en;

    logic        b_start = 0, b_abort = 0, b_valid = 0;
    logic [15:0] b_data = '0;
    logic        b_ready, b_busy, b_done;
    logic [15:0] b_cfg;
    logic [2:0]  b_en;

    lut_config_loader #(
        .INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(8), .NUM_LUTS(2)
    ) dut_a (
        .config_clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .config_data(a_cfg), .config_en(a_en), .busy(a_busy), .done(a_done)
    );

    lut_config_loader #(
        .INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(16), .NUM_LUTS(3)
    ) dut_b (
        .config_clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .config_data(b_cfg), .config_en(b_en), .busy(b_busy), .done(b_done)
    );

    int   n_pass = 0, n_total = 0;
    int   cyc = 0, a_lx = 0, b_lx = 0;
    int   a_done_n = 0, a_done_cyc = 0, a_viol = 0;
    int   b_done_n = 0, b_done_cyc = 0, b_viol = 0;
    com_t qa[$];
    com_t qb[$];
    vec_t vecs[4];

    always @(posedge clk) begin
        if (a_valid && a_ready) a_lx = cyc;
        if (b_valid && b_ready) b_lx = cyc;
        cyc++;
    end

    always @(negedge clk) begin
        if (a_en != '0) begin
            qa.push_back('{{1'b0, a_en}, a_cfg, cyc, cyc - a_lx});
            if (a_ready) a_viol++;
        end
        if (a_done) begin
            a_done_n++;
            a_done_cyc = cyc;
        end
        if (b_en != '0) begin
            qb.push_back('{b_en, b_cfg, cyc, cyc - b_lx});
            if (b_ready) b_viol++;
        end
        if (b_done) begin
            b_done_n++;
            b_done_cyc = cyc;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic a_send(input logic [7:0] w, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        a_valid = 1'b1;
        a_data  = w;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_ready_wait", a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic b_send(input logic [15:0] w);
        int n = 0;
        b_valid = 1'b1;
        b_data  = w;
        while (!b_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b_ready_wait", b_ready, 1);
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic a_wait_done(input string tag);
        int n = 0;
        while (a_done_n == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_done_count"}, a_done_n, 1);
    endtask

    task automatic a_clear();
        qa.delete();
        a_done_n = 0;
        a_viol   = 0;
    endtask

    task automatic a_start_pulse();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic a_check_pair(input string tag, input logic [15:0] e0,
                                input logic [15:0] e1);
        chk({tag, "_commits"}, qa.size(), 2);
        if (qa.size() == 2) begin
            chk({tag, "_lut0"}, {qa[0].en, qa[0].data}, {3'b001, e0});
            chk({tag, "_lut1"}, {qa[1].en, qa[1].data}, {3'b010, e1});
            chk({tag, "_lat"}, {qa[0].lat, qa[1].lat}, {32'd1, 32'd1});
            chk({tag, "_done_cyc"}, a_done_cyc, qa[1].cyc + 1);
        end
        chk({tag, "_ready_in_commit"}, a_viol, 0);
        chk({tag, "_idle"}, {a_busy, a_ready}, 0);
    endtask

    task automatic a_run(input vec_t v, input string tag);
        logic [7:0] ws[4];
        ws = '{v.w0, v.w1, v.w2, v.w3};
        a_clear();
        a_start_pulse();
        chk({tag, "_busy"}, a_busy, 1);
        for (int i = 0; i < 4; i++)
            a_send(ws[i], int'($urandom_range(0, v.gmax)));
        a_wait_done(tag);
        a_check_pair(tag, v.e0, v.e1);
    endtask

    initial begin
        vecs[0] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 0, 16'h1234, 16'hABCD};
        vecs[1] = '{8'hFF, 8'h00, 8'h01, 8'h80, 3, 16'h00FF, 16'h8001};
        vecs[2] = '{8'h5A, 8'hA5, 8'hC3, 8'h3C, 5, 16'hA55A, 16'h3CC3};
        vecs[3] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 2, 16'h0000, 16'hFFFF};

        repeat (2) @(negedge clk);
        chk("reset_a", {a_ready, a_en, a_busy, a_done, a_cfg}, 0);
        chk("reset_b", {b_ready, b_en, b_busy, b_done, b_cfg}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset while a table is half assembled.
        a_clear();
        a_start_pulse();
        a_send(8'h34, 0);
        rst = 1'b1;
        #1;
        chk("midreset_outputs", {a_ready, a_en, a_busy, a_done, a_cfg}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midreset_no_commit", qa.size() + a_done_n, 0);

        foreach (vecs[i]) a_run(vecs[i], $sformatf("vec%0d", i));

        // Abort coincident with the last word of LUT 1.
        a_clear();
        a_start_pulse();
        a_send(8'h34, 0);
        a_send(8'h12, 0);
        a_send(8'hCD, 0);
        a_valid = 1'b1;
        a_data  = 8'hAB;
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        a_valid = 1'b0;
        chk("abort_idle", {a_busy, a_ready}, 0);
        repeat (5) @(negedge clk);
        chk("abort_commits", qa.size(), 1);
        if (qa.size() == 1)
            chk("abort_lut0_kept", {qa[0].en, qa[0].data}, {3'b001, 16'h1234});
        chk("abort_no_done", a_done_n, 0);
        a_run(vecs[0], "restart");

        // Words offered in IDLE are not consumed.
        a_clear();
        a_valid = 1'b1;
        a_data  = 8'h77;
        repeat (3) @(negedge clk);
        chk("idle_word_refused", {a_ready, a_busy}, 0);
        a_valid = 1'b0;

        a_start = 1'b1;
        a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_abort = 1'b0;
        chk("start_abort_idle", {a_ready, a_busy}, 0);

        // A second start mid-load must not restart the sequence.
        a_start_pulse();
        a_send(8'h34, 1);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_send(8'h12, 0);
        a_send(8'hCD, 2);
        a_send(8'hAB, 0);
        a_wait_done("ignored");
        a_check_pair("ignored", 16'h1234, 16'hABCD);

        // One word per table, three LUTs.
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_send(16'hAAAA);
        b_send(16'h5555);
        b_send(16'h0F0F);
        for (int n = 0; n < 50 && b_done_n == 0; n++) @(negedge clk);
        @(negedge clk);
        chk("b_done_count", b_done_n, 1);
        chk("b_commits", qb.size(), 3);
        if (qb.size() == 3) begin
            chk("b_lut0", {qb[0].en, qb[0].data}, {3'b001, 16'hAAAA});
            chk("b_lut1", {qb[1].en, qb[1].data}, {3'b010, 16'h5555});
            chk("b_lut2", {qb[2].en, qb[2].data}, {3'b100, 16'h0F0F});
            chk("b_done_cyc", b_done_cyc, qb[2].cyc + 1);
        end
        chk("b_ready_in_commit", b_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
